dmem_arbiter: RTL and testbench

//  Shares the single data memory port between the core load/store path and a DMA/loader master.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core and a DMA/loader master
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_burst,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam bit CAN_BURST = MAX_BURST > 1;

    typedef enum logic {CORE_PRI, DMA_BURST} state_t;

    state_t        state, state_next;
    logic [SW-1:0] starve_cnt, starve_next;
    logic [BW-1:0] burst_cnt, burst_next;
    logic          burst_end;

    // arbitration state register
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state <= CORE_PRI;
        else state <= state_next;
    end

    // a burst ends when DMA drops, declines to continue, or completes its last allowed beat
    always_comb begin
        burst_end  = !dma_req || (dma_gnt && (!dma_burst || burst_cnt == LAST_BEAT));
        state_next = state;
        if (state == CORE_PRI) state_next = (dma_gnt && dma_burst && CAN_BURST) ? DMA_BURST : CORE_PRI;
        else state_next = burst_end ? CORE_PRI : DMA_BURST;
    end

    // grants (none while reset is held), stall and memory port mux
    always_comb begin
        dma_gnt    = rst && dma_req && (state == DMA_BURST || !core_req || starve_cnt == STARVE_MAX);
        core_gnt   = rst && core_req && !dma_gnt;
        core_stall = core_req && !core_gnt;
        mem_we     = (core_gnt && core_we) || (dma_gnt && dma_we);
        mem_addr   = dma_gnt ? dma_addr : core_addr;
        mem_wdata  = dma_gnt ? dma_wdata : core_wdata;
        core_rdata = mem_rdata;
    end

    // starvation and burst-length counters for the next cycle
    always_comb begin
        starve_next = (dma_gnt || !dma_req) ? '0 : (starve_cnt == STARVE_MAX ? starve_cnt : starve_cnt + 1'b1);
        if (state == DMA_BURST) burst_next = burst_end ? '0 : burst_cnt + 1'b1;
        else burst_next = (state_next == DMA_BURST) ? BW'(1) : '0;
    end

    // counters and the one-cycle-late DMA read return
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            burst_cnt  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            starve_cnt <= starve_next;
            burst_cnt  <= burst_next;
            dma_rvalid <= dma_gnt && !dma_we;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed multi-cycle sequences and a randomized run against a reference model
module tb_dmem_arbiter;
    localparam int SL = 4;
    localparam int MB = 8;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        core_req, core_we, core_gnt, core_stall;
    logic        dma_req, dma_we, dma_burst, dma_gnt, dma_rvalid, mem_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    int          checks = 0;
    int          failures = 0;
    int          waited = 0;
    int          beats = 0;
    bit          exp_rv = 1'b0;
    logic [31:0] exp_rd = '0;

    typedef struct {
        bit cr, cw; logic [31:0] ca, cd;
        bit dr, dw; logic [31:0] da, dd; bit db;
        bit xc, xd, xs, xrv, xre; logic [31:0] xrd;
    } vec_t;
    vec_t tv [15];

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
        .CLK(CLK), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_burst(dma_burst), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // data memory: combinational read, write on the edge ending the grant cycle
    always @(posedge CLK) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        waited = 0;
        beats  = 0;
        exp_rv = 1'b0;
    endtask

    // apply one cycle of inputs, compare against the model, then advance the model
    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd, input bit db);
        bit ec, ed;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_burst = db;
        #3;
        ed = dr && (beats > 0 || !cr || waited >= SL);
        ec = cr && !ed;
        check("dma_rvalid", dma_rvalid, exp_rv);
        if (exp_rv) check("dma_rdata", dma_rdata, exp_rd);
        check("core_gnt", core_gnt, ec);
        check("dma_gnt", dma_gnt, ed);
        check("core_stall", core_stall, cr && !ec);
        check("mem_we", mem_we, (ec && cw) || (ed && dw));
        if (ec || ed) check("mem_addr", mem_addr, ed ? da : ca);
        if ((ec && cw) || (ed && dw)) check("mem_wdata", mem_wdata, ed ? dd : cd);
        if (ec && !cw) check("core_rdata", core_rdata, ref_mem[ca[9:2]]);
        exp_rv = ed && !dw;
        if (exp_rv) exp_rd = ref_mem[da[9:2]];
        if (ec && cw) ref_mem[ca[9:2]] = cd;
        if (ed && dw) ref_mem[da[9:2]] = dd;
        if (!dr) beats = 0;
        else if (ed) beats = (db && beats + 1 < MB) ? beats + 1 : 0;
        waited = (dr && !ed) ? (waited < SL ? waited + 1 : SL) : 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int k, n, first_core, dma_run;
        bit d, core_done, rdr, rdw, rdb, last_dg;
        logic [31:0] rda, rdd;
        tv[0]  = '{H, H, 32'h40, 32'hDEADBEEF, L, L, 32'h0, 32'h0, L, H, L, L, H, L, 32'h0};
        tv[1]  = '{H, L, 32'h40, 32'h0, L, L, 32'h0, 32'h0, L, H, L, L, L, H, 32'hDEADBEEF};
        for (int i = 0; i < 10; i++) begin
            d = (i == 4) || (i == 9);
            tv[2+i] = '{H, L, 32'h40, 32'h0, H, H, 32'h200, 32'hCAFE0001, L, !d, d, d, L, !d, 32'hDEADBEEF};
        end
        tv[12] = '{H, H, 32'h80, 32'h12345678, L, L, 32'h0, 32'h0, L, H, L, L, L, L, 32'h0};
        tv[13] = '{L, L, 32'h0, 32'h0, H, L, 32'h80, 32'h0, L, L, H, L, L, L, 32'h0};
        tv[14] = '{L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, H, L, 32'h0};

        // reset held with both masters requesting
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_wdata = 32'h0; dma_burst = 1'b0;
        #12;
        check("t1_rvalid_in_reset", dma_rvalid, 0);
        check("t1_core_gnt_in_reset", core_gnt, 0);
        check("t1_dma_gnt_in_reset", dma_gnt, 0);
        tick();
        rst = 1'b1;
        model_reset();
        drive(H, L, 32'h0, 32'h0, H, L, 32'h200, 32'h0, L);
        check("t1_core_gnt_after", core_gnt, 1);
        check("t1_dma_gnt_after", dma_gnt, 0);
        tick();
        drive(L, L, 32'h0, 32'h0, H, L, 32'h200, 32'h0, L);
        tick();

        // core access, starvation pattern, DMA read return
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].cr, tv[i].cw, tv[i].ca, tv[i].cd, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd, tv[i].db);
            check($sformatf("tv%0d_core_gnt", i), core_gnt, tv[i].xc);
            check($sformatf("tv%0d_dma_gnt", i), dma_gnt, tv[i].xd);
            check($sformatf("tv%0d_core_stall", i), core_stall, tv[i].xs);
            check($sformatf("tv%0d_dma_rvalid", i), dma_rvalid, tv[i].xrv);
            if (tv[i].xre) check($sformatf("tv%0d_core_rdata", i), core_rdata, tv[i].xrd);
            tick();
        end
        check("t5_dma_rdata", dma_rdata, 32'h12345678);

        // 10-beat DMA burst with the core requesting from the second cycle until served once
        k = 0; n = 0; first_core = -1; dma_run = 0; core_done = 1'b0;
        while (k < 10 && n < 40) begin
            drive(n > 0 && !core_done, L, 32'h40, 32'h0, H, H, 32'h100 + 4 * k, 32'hA0000000 + k, H);
            if (core_gnt) begin
                core_done = 1'b1;
                if (first_core < 0) first_core = n;
            end
            if (dma_gnt) begin
                if (first_core < 0) dma_run++;
                k++;
            end
            tick();
            n++;
        end
        check("t4_beats_done", k, 10);
        check("t4_dma_run_before_core", dma_run, 8);
        check("t4_core_slot", first_core, 8);
        check("t4_total_cycles", n, 11);
        drive(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L);
        tick();
        for (int j = 0; j < 10; j++) check($sformatf("t4_ram%0d", j), ram[64+j], 32'hA0000000 + j);

        // reset asserted on the third beat of a burst
        for (int b = 0; b < 2; b++) begin
            drive(L, L, 32'h0, 32'h0, H, H, 32'h300 + 4 * b, 32'hB0000000 + b, H);
            tick();
        end
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h308; dma_wdata = 32'hB0000002; dma_burst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("t6_dma_gnt_in_reset", dma_gnt, 0);
        check("t6_mem_we_in_reset", mem_we, 0);
        tick();
        rst = 1'b1;
        model_reset();
        drive(H, L, 32'h40, 32'h0, H, H, 32'h308, 32'hB0000002, H);
        check("t6_core_wins_after_reset", core_gnt, 1);
        check("t6_beat3_unwritten", ram[194], 32'h0);
        check("t6_beat1_written", ram[192], 32'hB0000000);
        check("t6_beat2_written", ram[193], 32'hB0000001);
        tick();

        // randomized traffic; the DMA request is held stable until granted
        rdr = H; rdw = H; rda = 32'h308; rdd = 32'hB0000002; rdb = H; last_dg = L;
        for (int c = 0; c < 600; c++) begin
            if (!rdr || last_dg) begin
                rdr = $urandom_range(0, 3) != 0;
                rdw = 1'($urandom_range(0, 1));
                rda = 32'($urandom_range(0, 63)) << 2;
                rdd = $urandom;
                rdb = $urandom_range(0, 3) != 0;
            end
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                  $urandom, rdr, rdw, rda, rdd, rdb);
            last_dg = dma_gnt;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
